// File: rtl/knight_rider.sv
// Knight Rider LED scanner: a single lit LED bounces between bit 0 and bit 7,
// advancing one position every STEP_CYCLES enabled clock cycles.
// Optional feature macro KNIGHT_RIDER_TRAIL_EN: also light the previous head
// position, giving a two-LED trail.

module knight_rider #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] leds
);

    typedef enum logic {
        StRunLeft,
        StRunRight
    } dir_e;

    localparam logic [15:0] TickAt = 16'(STEP_CYCLES - 1);

    logic [15:0] prescaler_q, prescaler_d;
    logic [2:0]  head_q, head_d;
    dir_e        dir_q, dir_d;
    logic [7:0]  leds_q, leds_d;
    logic        tick;
`ifdef KNIGHT_RIDER_TRAIL_EN
    logic [2:0]  prev_q, prev_d;
`endif

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    // Prescaler: counts enabled cycles, ticks and wraps on the last one; frozen when disabled.
    always_comb begin
        tick        = enable && (prescaler_q == TickAt);
        prescaler_d = prescaler_q;
        if (enable) begin
            prescaler_d = tick ? 16'd0 : prescaler_q + 16'd1;
        end
    end

    // Head/direction stepping and next LED pattern, computed from the post-tick head.
    always_comb begin
        head_d = head_q;
        dir_d  = dir_q;
        if (tick) begin
            unique case (dir_q)
                StRunLeft: begin
                    head_d = head_q + 3'd1;
                    if (head_d == 3'd7) dir_d = StRunRight;
                end
                StRunRight: begin
                    head_d = head_q - 3'd1;
                    if (head_d == 3'd0) dir_d = StRunLeft;
                end
                default: dir_d = StRunLeft;
            endcase
        end
`ifdef KNIGHT_RIDER_TRAIL_EN
        prev_d = tick ? head_q : prev_q;
        leds_d = onehot(head_d) | onehot(prev_d);
`else
        leds_d = onehot(head_d);
`endif
    end

    // State and registered output; reset wins over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= 16'd0;
            head_q      <= 3'd0;
            dir_q       <= StRunLeft;
            leds_q      <= 8'h01;
`ifdef KNIGHT_RIDER_TRAIL_EN
            prev_q      <= 3'd0;
`endif
        end else begin
            prescaler_q <= prescaler_d;
            head_q      <= head_d;
            dir_q       <= dir_d;
            leds_q      <= leds_d;
`ifdef KNIGHT_RIDER_TRAIL_EN
            prev_q      <= prev_d;
`endif
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_knight_rider.sv
// Self-checking bench for knight_rider: directed vector table, hand-written
// multi-cycle sequences, and randomized enable/reset against a step-count model.
// Builds for either setting of KNIGHT_RIDER_TRAIL_EN.

module tb_knight_rider;

    logic       clk;
    logic       rst1, en1, rst4, en4;
    logic [7:0] leds1, leds4;

    int total;
    int passed;

`ifdef KNIGHT_RIDER_TRAIL_EN
    localparam logic [7:0] FREEZE_AT   = 8'h18;
    localparam logic [7:0] FREEZE_NEXT = 8'h30;
    localparam logic [7:0] MID_AT      = 8'hC0;
    localparam logic [7:0] MID_AFTER   = 8'h03;
    localparam logic [7:0] MID_AFTER2  = 8'h06;
    localparam logic [7:0] S1          = 8'h03;
    localparam logic [7:0] S2          = 8'h06;
`else
    localparam logic [7:0] FREEZE_AT   = 8'h10;
    localparam logic [7:0] FREEZE_NEXT = 8'h20;
    localparam logic [7:0] MID_AT      = 8'h40;
    localparam logic [7:0] MID_AFTER   = 8'h02;
    localparam logic [7:0] MID_AFTER2  = 8'h04;
    localparam logic [7:0] S1          = 8'h02;
    localparam logic [7:0] S2          = 8'h04;
`endif

    knight_rider #(.STEP_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .enable(en1),
        .leds  (leds1)
    );

    knight_rider #(.STEP_CYCLES(4)) dut4 (
        .clk   (clk),
        .reset (rst4),
        .enable(en4),
        .leds  (leds4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[39];
    logic [7:0] bounce[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    endtask

    // Head position after n steps from reset: 0..7 then back down, period 14.
    function automatic int pos(input int n);
        int m;
        m = n % 14;
        return (m <= 7) ? m : 14 - m;
    endfunction

    function automatic logic [7:0] model_leds(input int n);
        logic [7:0] v;
        v = 8'd1 << pos(n);
`ifdef KNIGHT_RIDER_TRAIL_EN
        if (n > 0) v = v | (8'd1 << pos(n - 1));
`endif
        return v;
    endfunction

    initial begin
        int n1, c1, n4, c4;
        logic r1, e1, r4, e4;
        total  = 0;
        passed = 0;
        rst1 = 1'b1; en1 = 1'b0; rst4 = 1'b1; en4 = 1'b0;

`ifdef KNIGHT_RIDER_TRAIL_EN
        bounce = '{8'h03, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60,
                   8'hC0, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06};
`else
        bounce = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                   8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
`endif
        // Reset, 10 frozen cycles, then two full bounces at one step per cycle.
        vecs[0] = '{rst: 1'b1, en: 1'b0, exp: 8'h01};
        for (int i = 1; i <= 10; i++) vecs[i] = '{rst: 1'b0, en: 1'b0, exp: 8'h01};
        for (int i = 11; i <= 38; i++) vecs[i] = '{rst: 1'b0, en: 1'b1, exp: bounce[(i - 10) % 14]};

        for (int i = 0; i < 39; i++) begin
            rst1 = vecs[i].rst;
            en1  = vecs[i].en;
            step();
            check($sformatf("vec%0d", i), leds1, vecs[i].exp);
        end

        // Freeze mid-sweep, then resume.
        rst1 = 1'b1; en1 = 1'b0;
        step();
        rst1 = 1'b0; en1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (leds1 == FREEZE_AT) break;
            step();
        end
        check("freeze_reach", leds1, FREEZE_AT);
        en1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("freeze_hold%0d", i), leds1, FREEZE_AT);
        end
        en1 = 1'b1;
        step();
        check("freeze_resume", leds1, FREEZE_NEXT);

        // Reset while running right; reset dominates enable.
        rst1 = 1'b1;
        step();
        rst1 = 1'b0; en1 = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("mid_at", leds1, MID_AT);
        rst1 = 1'b1;
        step();
        check("mid_reset", leds1, 8'h01);
        rst1 = 1'b0;
        step();
        check("mid_after", leds1, MID_AFTER);
        step();
        check("mid_after2", leds1, MID_AFTER2);

        // Prescaler of 4, with a pause that must keep the partial count.
        rst4 = 1'b1; en4 = 1'b0;
        step();
        check("pre_reset", leds4, 8'h01);
        rst4 = 1'b0; en4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("pre_wait%0d", i), leds4, 8'h01);
        end
        step();
        check("pre_step1", leds4, S1);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("pre_cnt%0d", i), leds4, S1);
        end
        en4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("pre_hold%0d", i), leds4, S1);
        end
        en4 = 1'b1;
        step();
        check("pre_cnt3", leds4, S1);
        step();
        check("pre_step2", leds4, S2);

        // Reset with a partial prescaler count must restart the count.
        step();
        step();
        rst4 = 1'b1;
        step();
        check("pre_midreset", leds4, 8'h01);
        rst4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("pre_restart%0d", i), leds4, 8'h01);
        end
        step();
        check("pre_restart_step", leds4, S1);

        // Randomized enable and occasional reset against the model.
        rst1 = 1'b1; rst4 = 1'b1; en1 = 1'b1; en4 = 1'b1;
        step();
        n1 = 0; c1 = 0; n4 = 0; c4 = 0;
        for (int i = 0; i < 600; i++) begin
            r1 = ($urandom_range(0, 29) == 0);
            e1 = ($urandom_range(0, 3) != 0);
            r4 = ($urandom_range(0, 49) == 0);
            e4 = ($urandom_range(0, 3) != 0);
            rst1 = r1; en1 = e1; rst4 = r4; en4 = e4;
            step();
            if (r1) begin
                n1 = 0; c1 = 0;
            end else if (e1) begin
                n1++;
            end
            if (r4) begin
                n4 = 0; c4 = 0;
            end else if (e4) begin
                if (c4 == 3) begin
                    c4 = 0; n4++;
                end else begin
                    c4++;
                end
            end
            check($sformatf("rand1_%0d", i), leds1, model_leds(n1));
            check($sformatf("rand4_%0d", i), leds4, model_leds(n4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/knight_rider.md
KNIGHT_RIDER -- requirements
Module: knight_rider

Interface
REQ-001 SHALL provide parameter: STEP_CYCLES, 1, enabled clock cycles per LED step (legal range 1..65535).
REQ-002 SHALL provide port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: enable  input  1  high = animation advances; low = freeze all state.
REQ-005 SHALL provide port: leds  output  8  LED pattern, bit0 = rightmost LED; registered output.

Function
REQ-006 SHALL hold internal state: head position 0..7, direction FSM {RUN_LEFT, RUN_RIGHT}, prescaler counter 16 bits.
REQ-007 SHALL raise a step tick in any cycle where enable=1 and prescaler == STEP_CYCLES-1; prescaler then wraps to 0, else increments while enable=1.
REQ-008 SHALL hold prescaler, head and FSM unchanged while enable=0, without losing a partial count.
REQ-009 SHALL, in RUN_LEFT on a tick, move head up by one; when the new head is 7, switch to RUN_RIGHT.
REQ-010 SHALL, in RUN_RIGHT on a tick, move head down by one; when the new head is 0, switch to RUN_LEFT.
REQ-011 SHALL produce the bounce sequence 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80,0x40,...,0x02,0x01,0x02,...; each end LED is lit for exactly one step per pass; period 14 steps.
REQ-012 SHALL update leds on the same rising edge as the tick, i.e. one-cycle latency from the qualifying enabled cycle.
REQ-013 SHALL never output 0x00 or more than the permitted lit bits (one bit; two with trail).
REQ-014 SHALL treat reset as dominant over enable when both are high in the same cycle.

Reset
REQ-015 SHALL, on a rising edge with reset=1, set leds=0x01, head=0, FSM=RUN_LEFT, prescaler=0, trail cleared.
REQ-016 SHALL, when reset is asserted mid-sequence (any head, any direction, any prescaler value), restart from the REQ-015 state on the next edge.
REQ-017 SHALL, with STEP_CYCLES=1, show leds=0x02 after the first rising edge with reset=0 and enable=1.

Configuration
REQ-018 SHALL support macro KNIGHT_RIDER_TRAIL_EN.
REQ-019 SHALL, with KNIGHT_RIDER_TRAIL_EN defined, drive leds = one-hot(head) OR one-hot(previous head); previous head is captured on each tick and cleared by reset, so sequence is 0x01,0x03,0x06,0x0C,0x18,0x30,0x60,0xC0,0xC0,0x60,...,0x03,0x03,0x06,...
REQ-020 SHALL, without the macro, drive leds = one-hot(head) only and synthesize no trail register.

Verification
REQ-021 Reset: reset=1 for 1 cycle, enable=0 -> leds=0x01; hold enable=0 for 10 cycles -> leds stays 0x01.
REQ-022 Full bounce, STEP_CYCLES=1: release reset, enable=1 for 28 cycles -> leds follows REQ-011 exactly twice, back to 0x01 at cycle 14 and 28.
REQ-023 Freeze: enable=1 until leds=0x10, drop enable for 5 cycles -> leds holds 0x10; re-enable -> next value 0x20.
REQ-024 Prescaler, STEP_CYCLES=4: enable=1 -> leds changes every 4th cycle (0x01 for 3 cycles, 0x02 on 4th edge); enable low for 2 cycles after 2 counts -> step arrives after 2 further enabled cycles.
REQ-025 Mid-run reset: while leds=0x40 in RUN_RIGHT, pulse reset with enable=1 -> leds=0x01 next edge, then 0x02 (moving left).
REQ-026 Trail build (KNIGHT_RIDER_TRAIL_EN): 10 enabled steps from reset -> 0x03,0x06,0x0C,0x18,0x30,0x60,0xC0,0xC0,0x60,0x30.
